// File: rtl/id_ex_issue.sv
// ID->EX pipeline register with a load-use interlock, EX backpressure, branch flush
// and a saturating stall-cycle counter with a sticky over-long-stall flag.
module id_ex_issue #(
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_imm,
    input  logic [3:0]        id_rs1,
    input  logic [3:0]        id_rs2,
    input  logic [3:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_regfile_we,
    input  logic              id_is_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       rs1_data_ID,
    input  logic [31:0]       rs2_data_ID,
    input  logic              rs1_data_forwarded,
    input  logic              rs2_data_forwarded,
    input  logic              regfile_we_EX,
    input  logic              regfile_we_MEMPREP,
    input  logic              regfile_we_MEMEX,
    input  logic              regfile_we_WB,
    input  logic [3:0]        rd_EX,
    input  logic [3:0]        rd_MEMPREP,
    input  logic [3:0]        rd_MEMEX,
    input  logic [3:0]        rd_WB,
    input  logic              is_load_EX,
    input  logic              is_load_MEMPREP,
    input  logic              is_load_MEMEX,
    input  logic              is_load_WB,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              id_ready,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_imm,
    output logic [31:0]       ex_rs1_data,
    output logic [31:0]       ex_rs2_data,
    output logic [3:0]        ex_rd,
    output logic              ex_regfile_we,
    output logic              ex_is_load,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [1:0]        ex_fwd_mask,
    output logic [CNT_W-1:0]  stall_count,
    output logic              stall_timeout
);

    typedef enum logic {RUN, LU_STALL} state_t;

    localparam int RUN_W = $clog2(MAX_STALL + 1) + 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic             hit_rs1, hit_rs2, hazard, slot_free;

    function automatic logic ld_hit(input logic [3:0] r,
                                    input logic [3:0] ld_rd_mask_ex,
                                    input logic [3:0] ld_rd_mask_mp,
                                    input logic [3:0] ld_rd_mask_me,
                                    input logic [3:0] ld_rd_mask_wb,
                                    input logic [3:0] ld_en);
        ld_hit = (r != 4'd0) &&
                 ((ld_en[0] && ld_rd_mask_ex == r) ||
                  (ld_en[1] && ld_rd_mask_mp == r) ||
                  (ld_en[2] && ld_rd_mask_me == r) ||
                  (ld_en[3] && ld_rd_mask_wb == r));
    endfunction

    logic [3:0] ld_en;

    always_comb begin
        ld_en     = {regfile_we_WB & is_load_WB, regfile_we_MEMEX & is_load_MEMEX,
                     regfile_we_MEMPREP & is_load_MEMPREP, regfile_we_EX & is_load_EX};
        hit_rs1   = ld_hit(id_rs1, rd_EX, rd_MEMPREP, rd_MEMEX, rd_WB, ld_en);
        hit_rs2   = ld_hit(id_rs2, rd_EX, rd_MEMPREP, rd_MEMEX, rd_WB, ld_en);
        hazard    = id_valid & ((id_uses_rs1 & hit_rs1) | (id_uses_rs2 & hit_rs2));
        slot_free = !ex_valid | ex_ready;
        if (flush)           id_ready = 1'b1;
        else if (!slot_free) id_ready = 1'b0;
        else if (hazard)     id_ready = 1'b0;
        else                 id_ready = id_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            run_cnt       <= '0;
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_imm        <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_rd         <= '0;
            ex_regfile_we <= 1'b0;
            ex_is_load    <= 1'b0;
            ex_ctrl       <= '0;
            ex_fwd_mask   <= '0;
            stall_count   <= '0;
            stall_timeout <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            state    <= RUN;
            run_cnt  <= '0;
        end else if (slot_free) begin
            if (hazard) begin
                ex_valid <= 1'b0;
                state    <= LU_STALL;
                if (stall_count != '1)
                    stall_count <= stall_count + 1'b1;
                if (run_cnt != RUN_MAX)
                    run_cnt <= run_cnt + 1'b1;
                // MAX_STALL bubbles already taken and the hazard is still there
                if (state == LU_STALL && run_cnt >= RUN_MAX)
                    stall_timeout <= 1'b1;
            end else if (id_valid) begin
                ex_valid      <= 1'b1;
                ex_pc         <= id_pc;
                ex_imm        <= id_imm;
                ex_rs1_data   <= rs1_data_ID;
                ex_rs2_data   <= rs2_data_ID;
                ex_rd         <= id_rd;
                ex_regfile_we <= id_regfile_we;
                ex_is_load    <= id_is_load;
                ex_ctrl       <= id_ctrl;
                ex_fwd_mask   <= {rs2_data_forwarded, rs1_data_forwarded};
                state         <= RUN;
                run_cnt       <= '0;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule
